reg_xfer_ctrl: RTL and testbench
================================

Name: reg_xfer_ctrl

Overview:
- Sequencer for the 8080 general-register bank: eight 8-bit registers, each with its own read enable, write enable and tri-state output onto one shared internal bus.
- Accepts register-transfer commands (MOV, LOAD, STORE, SWAP) over a valid/ready handshake.
- Generates one-hot read/write strobes and drives the bus from its own temp registers.
- Guarantees no two bus drivers are ever active in the same cycle.

Parameters:
- DW, 8, data/bus width in bits.
- M_CODE, 6, register code reserved for memory operand (M); rejected by this block.

Ports:
- clk50M_i  in  1  system clock, 50 MHz.
- rst_ni  in  1  asynchronous reset, active-low.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  block idle, can accept a command.
- cmd_op_i  in  2  00 MOV, 01 LOAD, 10 STORE, 11 SWAP.
- cmd_src_i  in  3  source register code (B=0 C=1 D=2 E=3 H=4 L=5 A=7).
- cmd_dst_i  in  3  destination register code.
- ext_data_i  in  DW  LOAD data, sampled at accept.
- ext_data_o  out  DW  STORE result, held until the next STORE completes.
- done_o  out  1  one-cycle pulse on the final cycle of a command.
- err_o  out  1  one-cycle pulse: command rejected.
- reg_rd_o  out  8  one-hot read enables to the register bank.
- reg_wr_o  out  8  one-hot write enables to the register bank.
- bus_i  in  DW  shared internal bus (register outputs).
- bus_o  out  DW  value this block drives onto the bus.
- bus_oe_o  out  1  this block drives the bus.

Behaviour:
- Reset (async, immediate): state IDLE; cmd_ready_o=1; done_o, err_o, bus_oe_o=0; reg_rd_o, reg_wr_o=0; tmp0, tmp1, ext_data_o, bus_o=0.
- Accept: a command is accepted on a rising edge with cmd_valid_i && cmd_ready_o. cmd_ready_o=1 only in IDLE.
- Latching at accept: op, src, dst and ext_data_i are latched; later changes on these inputs are ignored.
- Reject: if a used code equals M_CODE (src for MOV/STORE/SWAP, dst for MOV/LOAD/SWAP), go to ERR for one cycle: err_o=1, no strobes, no register or output changes, then IDLE.
- States: IDLE, RD0, RD1, WR0, WR1, ERR. All outputs are Moore-decoded from the state register.
- RDx: reg_rd_o=onehot(code), bus_oe_o=0. The temp register captures bus_i at the closing edge.
- WRx: bus_oe_o=1, bus_o=temp, reg_wr_o=onehot(code). The bank captures at the closing edge.
- MOV: RD0(src→tmp0) → WR0(tmp0→dst, done). 2 cycles after accept.
- LOAD: tmp0<=ext_data_i at accept → WR0(dst, done). 1 cycle.
- STORE: RD0(src→tmp0) → WR0 with no strobes, bus_oe_o=0, ext_data_o<=tmp0, done. 2 cycles.
- SWAP: RD0(src→tmp0) → RD1(dst→tmp1) → WR0(tmp0→dst) → WR1(tmp1→src, done). 4 cycles.
- Invariants, every cycle:
  - reg_rd_o and reg_wr_o are each zero or one-hot.
  - bus_oe_o and any reg_rd_o bit are never both 1.
  - Never more than one write per cycle.
- Next command: done_o is asserted in the last busy state; the next cycle is IDLE with cmd_ready_o=1. Throughput is one command per (latency+1) cycles.
- src==dst: executed normally. MOV/SWAP rewrite the same value; the register is unchanged.
- cmd_valid_i while busy: ignored and not queued. The requester holds it until ready.
- Reset mid-command: strobes drop asynchronously and the partial transfer is abandoned. Any register already written keeps its new value (e.g. SWAP reset after WR0 leaves dst updated).

Test Plan:
- Reset, then preload B=0x12 via LOAD(dst=0,ext=0x12) → reg_wr_o=0x01 and bus_o=0x12 for one cycle, done_o pulses 1 cycle after accept.
- MOV src=B(0) dst=A(7), bus_i=0x12 in RD0 → reg_rd_o=0x01, then reg_wr_o=0x80 with bus_o=0x12; done_o at cycle 2; bus_oe_o never overlaps reg_rd_o.
- STORE src=L(5), bus_i=0xA5 → reg_rd_o=0x20 one cycle, ext_data_o=0xA5 after done_o, reg_wr_o stays 0.
- SWAP src=D(2)=0x3C, dst=E(3)=0xC3 → rd 0x04, rd 0x08, wr 0x08 with bus_o=0x3C, wr 0x04 with bus_o=0xC3; done_o on cycle 4.
- MOV src=6 (M) → err_o 1-cycle pulse, reg_rd_o/reg_wr_o/bus_oe_o stay 0, cmd_ready_o returns next cycle.
- SWAP with rst_ni low during WR0 → all strobes 0 immediately, cmd_ready_o=1 after release, ext_data_o=0; a new MOV then completes normally.

Source files
------------

// File: rtl/reg_xfer_ctrl_if.sv
// Command handshake and register-bank bus bundle for reg_xfer_ctrl.
// The slave modport is the sequencer itself; the master modport is the
// requester plus the register bank that shares the internal bus.
interface reg_xfer_ctrl_if #(
  parameter int DW = 8
) ();

  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic [1:0]    cmd_op_i;
  logic [2:0]    cmd_src_i;
  logic [2:0]    cmd_dst_i;
  logic [DW-1:0] ext_data_i;
  logic [DW-1:0] ext_data_o;
  logic          done_o;
  logic          err_o;
  logic [7:0]    reg_rd_o;
  logic [7:0]    reg_wr_o;
  logic [DW-1:0] bus_i;
  logic [DW-1:0] bus_o;
  logic          bus_oe_o;

  modport master (
    output cmd_valid_i, cmd_op_i, cmd_src_i, cmd_dst_i, ext_data_i, bus_i,
    input  cmd_ready_o, ext_data_o, done_o, err_o,
           reg_rd_o, reg_wr_o, bus_o, bus_oe_o
  );

  modport slave (
    input  cmd_valid_i, cmd_op_i, cmd_src_i, cmd_dst_i, ext_data_i, bus_i,
    output cmd_ready_o, ext_data_o, done_o, err_o,
           reg_rd_o, reg_wr_o, bus_o, bus_oe_o
  );

endinterface

// File: rtl/reg_xfer_ctrl.sv
// Register-transfer sequencer for the 8080 general-register bank.
// Runs MOV / LOAD / STORE / SWAP as a short sequence of one-hot read and
// write strobes, moving data through two private temp registers. Every
// output is registered and follows the state, so read strobes and the
// bus drive can never overlap within a cycle.
module reg_xfer_ctrl #(
  parameter int         DW     = 8,
  parameter logic [2:0] M_CODE = 3'd6
) (
  input logic             clk50M_i,
  input logic             rst_ni,
  reg_xfer_ctrl_if.slave  xfer
);

  typedef enum logic [2:0] {
    IDLE,
    RD0,
    RD1,
    WR0,
    WR1,
    ERR
  } state_t;

  typedef enum logic [1:0] {
    OP_MOV   = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10,
    OP_SWAP  = 2'b11
  } op_t;

  state_t        state;
  op_t           op_q;
  logic [2:0]    src_q;
  logic [2:0]    dst_q;
  logic [DW-1:0] tmp0;
  logic [DW-1:0] tmp1;

  logic          ready_q;
  logic          done_q;
  logic          err_q;
  logic [7:0]    rd_q;
  logic [7:0]    wr_q;
  logic          oe_q;
  logic [DW-1:0] bus_q;
  logic [DW-1:0] ext_q;

  op_t  op_in;
  logic src_is_m;
  logic dst_is_m;
  logic reject;

  function automatic logic [7:0] onehot(input logic [2:0] code);
    return 8'h01 << code;
  endfunction

  // A code is only rejected where the operation actually uses it: LOAD never
  // reads a source register and STORE never writes a destination register.
  always_comb begin
    op_in    = op_t'(xfer.cmd_op_i);
    src_is_m = (xfer.cmd_src_i == M_CODE);
    dst_is_m = (xfer.cmd_dst_i == M_CODE);
    reject   = 1'b0;
    unique case (op_in)
      OP_MOV:   reject = src_is_m || dst_is_m;
      OP_LOAD:  reject = dst_is_m;
      OP_STORE: reject = src_is_m;
      OP_SWAP:  reject = src_is_m || dst_is_m;
      default:  reject = 1'b0;
    endcase
  end

  // Sequencer: state, latched command, temps and every registered output.
  // Outputs for a state are loaded on the edge that enters it; when a temp
  // is captured on the same edge that starts driving it, bus_i is forwarded.
  always_ff @(posedge clk50M_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      op_q    <= OP_MOV;
      src_q   <= '0;
      dst_q   <= '0;
      tmp0    <= '0;
      tmp1    <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= '0;
      wr_q    <= '0;
      oe_q    <= 1'b0;
      bus_q   <= '0;
      ext_q   <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      rd_q   <= '0;
      wr_q   <= '0;
      oe_q   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (xfer.cmd_valid_i) begin
            op_q    <= op_in;
            src_q   <= xfer.cmd_src_i;
            dst_q   <= xfer.cmd_dst_i;
            ready_q <= 1'b0;
            if (reject) begin
              err_q <= 1'b1;
              state <= ERR;
            end else if (op_in == OP_LOAD) begin
              tmp0   <= xfer.ext_data_i;
              bus_q  <= xfer.ext_data_i;
              oe_q   <= 1'b1;
              wr_q   <= onehot(xfer.cmd_dst_i);
              done_q <= 1'b1;
              state  <= WR0;
            end else begin
              rd_q  <= onehot(xfer.cmd_src_i);
              state <= RD0;
            end
          end
        end
        RD0: begin
          tmp0 <= xfer.bus_i;
          unique case (op_q)
            OP_SWAP: begin
              rd_q  <= onehot(dst_q);
              state <= RD1;
            end
            OP_STORE: begin
              ext_q  <= xfer.bus_i;
              done_q <= 1'b1;
              state  <= WR0;
            end
            default: begin
              bus_q  <= xfer.bus_i;
              oe_q   <= 1'b1;
              wr_q   <= onehot(dst_q);
              done_q <= 1'b1;
              state  <= WR0;
            end
          endcase
        end
        RD1: begin
          tmp1  <= xfer.bus_i;
          bus_q <= tmp0;
          oe_q  <= 1'b1;
          wr_q  <= onehot(dst_q);
          state <= WR0;
        end
        WR0: begin
          if (op_q == OP_SWAP) begin
            bus_q  <= tmp1;
            oe_q   <= 1'b1;
            wr_q   <= onehot(src_q);
            done_q <= 1'b1;
            state  <= WR1;
          end else begin
            ready_q <= 1'b1;
            state   <= IDLE;
          end
        end
        WR1: begin
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        ERR: begin
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign xfer.cmd_ready_o = ready_q;
  assign xfer.done_o      = done_q;
  assign xfer.err_o       = err_q;
  assign xfer.reg_rd_o    = rd_q;
  assign xfer.reg_wr_o    = wr_q;
  assign xfer.bus_oe_o    = oe_q;
  assign xfer.bus_o       = bus_q;
  assign xfer.ext_data_o  = ext_q;

endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// Bench for reg_xfer_ctrl: models the 8-entry register bank on the shared
// bus, predicts the strobe sequence of each command from its operation and
// tracks expected register contents at the transaction level.
module tb_reg_xfer_ctrl;

  localparam int         DW       = 8;
  localparam logic [2:0] M_CODE   = 3'd6;
  localparam logic [1:0] OP_MOV   = 2'd0;
  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_STORE = 2'd2;
  localparam logic [1:0] OP_SWAP  = 2'd3;

  typedef struct packed {
    logic [7:0] rd;
    logic [7:0] wr;
    logic       oe;
    logic [7:0] bus;
    logic       done;
    logic       err;
  } cyc_t;

  logic clk50M = 1'b0;
  logic rst_n  = 1'b0;
  int   total  = 0;
  int   bad    = 0;

  logic [7:0] bank [8] = '{default: 8'h00};
  logic [7:0] ref_regs [8];
  logic [7:0] exp_ext;
  logic [7:0] bus_val;

  reg_xfer_ctrl_if #(.DW(DW)) xif ();

  reg_xfer_ctrl #(
    .DW    (DW),
    .M_CODE(M_CODE)
  ) dut (
    .clk50M_i(clk50M),
    .rst_ni  (rst_n),
    .xfer    (xif.slave)
  );

  // 50 MHz clock
  always #10 clk50M = ~clk50M;

  // Shared internal bus: the sequencer or whichever register is read drives it
  always_comb begin
    bus_val = 8'h00;
    if (xif.bus_oe_o) bus_val = xif.bus_o;
    for (int i = 0; i < 8; i++)
      if (xif.reg_rd_o[i]) bus_val = bank[i];
  end

  assign xif.bus_i = bus_val;

  // Register bank captures the bus on every enabled write strobe
  always @(posedge clk50M) begin
    for (int i = 0; i < 8; i++)
      if (xif.reg_wr_o[i]) bank[i] <= xif.bus_i;
  end

  function automatic logic [7:0] oh(input logic [2:0] code);
    logic [7:0] v;
    v = 8'h00;
    v[code] = 1'b1;
    return v;
  endfunction

  function automatic cyc_t mk(input logic [7:0] rd, input logic [7:0] wr,
                              input logic oe, input logic [7:0] bus,
                              input logic done, input logic err);
    cyc_t c;
    c.rd = rd; c.wr = wr; c.oe = oe; c.bus = bus; c.done = done; c.err = err;
    return c;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Busy-time noise on the command inputs: must be neither accepted nor latched
  task automatic scramble();
    xif.cmd_valid_i = 1'($urandom);
    xif.cmd_op_i    = 2'($urandom);
    xif.cmd_src_i   = 3'($urandom);
    xif.cmd_dst_i   = 3'($urandom);
    xif.ext_data_i  = 8'($urandom);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_ready"}, 32'(xif.cmd_ready_o), 32'd1);
    checkOutput({tag, "_rd"},    32'(xif.reg_rd_o),    32'd0);
    checkOutput({tag, "_wr"},    32'(xif.reg_wr_o),    32'd0);
    checkOutput({tag, "_oe"},    32'(xif.bus_oe_o),    32'd0);
    checkOutput({tag, "_done"},  32'(xif.done_o),      32'd0);
    checkOutput({tag, "_err"},   32'(xif.err_o),       32'd0);
  endtask

  // Issue one command from a falling edge with the block idle and check it
  // cycle by cycle; returns on the falling edge of the following idle cycle.
  task automatic applyStimulus(input logic [1:0] op, input logic [2:0] src,
                               input logic [2:0] dst, input logic [7:0] ext);
    cyc_t       exp_q [$];
    logic       rejected;
    logic [7:0] vs;
    logic [7:0] vd;
    vs = ref_regs[src];
    vd = ref_regs[dst];
    rejected = (src == M_CODE && op != OP_LOAD) || (dst == M_CODE && op != OP_STORE);
    if (rejected)
      exp_q.push_back(mk(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1));
    else begin
      case (op)
        OP_MOV: begin
          exp_q.push_back(mk(oh(src), 8'h00, 1'b0, 8'h00, 1'b0, 1'b0));
          exp_q.push_back(mk(8'h00, oh(dst), 1'b1, vs, 1'b1, 1'b0));
        end
        OP_LOAD:
          exp_q.push_back(mk(8'h00, oh(dst), 1'b1, ext, 1'b1, 1'b0));
        OP_STORE: begin
          exp_q.push_back(mk(oh(src), 8'h00, 1'b0, 8'h00, 1'b0, 1'b0));
          exp_q.push_back(mk(8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0));
        end
        default: begin
          exp_q.push_back(mk(oh(src), 8'h00, 1'b0, 8'h00, 1'b0, 1'b0));
          exp_q.push_back(mk(oh(dst), 8'h00, 1'b0, 8'h00, 1'b0, 1'b0));
          exp_q.push_back(mk(8'h00, oh(dst), 1'b1, vs, 1'b0, 1'b0));
          exp_q.push_back(mk(8'h00, oh(src), 1'b1, vd, 1'b1, 1'b0));
        end
      endcase
    end

    checkOutput("ready_pre", 32'(xif.cmd_ready_o), 32'd1);
    xif.cmd_valid_i = 1'b1;
    xif.cmd_op_i    = op;
    xif.cmd_src_i   = src;
    xif.cmd_dst_i   = dst;
    xif.ext_data_i  = ext;
    @(posedge clk50M);
    #1 scramble();

    foreach (exp_q[k]) begin
      @(negedge clk50M);
      checkOutput("rd",    32'(xif.reg_rd_o),    32'(exp_q[k].rd));
      checkOutput("wr",    32'(xif.reg_wr_o),    32'(exp_q[k].wr));
      checkOutput("oe",    32'(xif.bus_oe_o),    32'(exp_q[k].oe));
      checkOutput("done",  32'(xif.done_o),      32'(exp_q[k].done));
      checkOutput("err",   32'(xif.err_o),       32'(exp_q[k].err));
      checkOutput("ready", 32'(xif.cmd_ready_o), 32'd0);
      if (exp_q[k].oe)
        checkOutput("bus_o", 32'(xif.bus_o), 32'(exp_q[k].bus));
      scramble();
    end

    @(negedge clk50M);
    checkIdle("post");

    if (!rejected) begin
      case (op)
        OP_MOV:   ref_regs[dst] = vs;
        OP_LOAD:  ref_regs[dst] = ext;
        OP_STORE: exp_ext = vs;
        default: begin
          ref_regs[dst] = vs;
          ref_regs[src] = vd;
        end
      endcase
    end
    checkOutput("ext_data_o", 32'(xif.ext_data_o), 32'(exp_ext));
    checkOutput("bank_src",   32'(bank[src]),      32'(ref_regs[src]));
    checkOutput("bank_dst",   32'(bank[dst]),      32'(ref_regs[dst]));
    xif.cmd_valid_i = 1'b0;
  endtask

  // SWAP interrupted by reset while the given busy cycle (1..4) is showing
  task automatic resetDuringSwap(input logic [2:0] src, input logic [2:0] dst,
                                 input int stage);
    logic [7:0] vs;
    vs = ref_regs[src];
    xif.cmd_valid_i = 1'b1;
    xif.cmd_op_i    = OP_SWAP;
    xif.cmd_src_i   = src;
    xif.cmd_dst_i   = dst;
    @(posedge clk50M);
    #1 scramble();
    repeat (stage) @(negedge clk50M);
    rst_n = 1'b0;
    xif.cmd_valid_i = 1'b0;
    #1;
    checkIdle("rst_mid");
    checkOutput("rst_ext", 32'(xif.ext_data_o), 32'd0);
    checkOutput("rst_bus", 32'(xif.bus_o),      32'd0);
    @(posedge clk50M);
    @(negedge clk50M);
    rst_n = 1'b1;
    if (stage >= 4) ref_regs[dst] = vs;
    exp_ext = 8'h00;
    @(negedge clk50M);
    checkIdle("rst_rel");
    checkOutput("rst_bank_src", 32'(bank[src]), 32'(ref_regs[src]));
    checkOutput("rst_bank_dst", 32'(bank[dst]), 32'(ref_regs[dst]));
  endtask

  // Main sequence: reset, directed cases, reset abort, then random traffic
  initial begin
    logic [2:0] s;
    logic [2:0] d;
    for (int i = 0; i < 8; i++) ref_regs[i] = 8'h00;
    exp_ext         = 8'h00;
    xif.cmd_valid_i = 1'b0;
    xif.cmd_op_i    = 2'd0;
    xif.cmd_src_i   = 3'd0;
    xif.cmd_dst_i   = 3'd0;
    xif.ext_data_i  = 8'h00;

    repeat (3) @(negedge clk50M);
    checkIdle("reset");
    checkOutput("reset_ext", 32'(xif.ext_data_o), 32'd0);
    checkOutput("reset_bus", 32'(xif.bus_o),      32'd0);
    rst_n = 1'b1;
    @(negedge clk50M);
    checkIdle("released");

    $display("[TB] directed commands");
    applyStimulus(OP_LOAD,  3'd0, 3'd0, 8'h12);
    applyStimulus(OP_MOV,   3'd0, 3'd7, 8'h00);
    applyStimulus(OP_LOAD,  3'd0, 3'd5, 8'hA5);
    applyStimulus(OP_STORE, 3'd5, 3'd0, 8'h00);
    applyStimulus(OP_LOAD,  3'd0, 3'd2, 8'h3C);
    applyStimulus(OP_LOAD,  3'd0, 3'd3, 8'hC3);
    applyStimulus(OP_SWAP,  3'd2, 3'd3, 8'h00);
    applyStimulus(OP_SWAP,  3'd4, 3'd4, 8'h00);
    applyStimulus(OP_MOV,   3'd6, 3'd1, 8'h00);
    applyStimulus(OP_MOV,   3'd1, 3'd6, 8'h00);
    applyStimulus(OP_LOAD,  3'd0, 3'd6, 8'h77);
    applyStimulus(OP_STORE, 3'd6, 3'd0, 8'h00);
    applyStimulus(OP_SWAP,  3'd3, 3'd6, 8'h00);
    applyStimulus(OP_LOAD,  3'd6, 3'd1, 8'h5A);
    applyStimulus(OP_STORE, 3'd1, 3'd6, 8'h00);

    $display("[TB] reset during swap");
    resetDuringSwap(3'd2, 3'd3, 3);
    applyStimulus(OP_MOV,  3'd3, 3'd4, 8'h00);
    applyStimulus(OP_LOAD, 3'd0, 3'd1, 8'h9E);
    resetDuringSwap(3'd1, 3'd4, 4);
    applyStimulus(OP_STORE, 3'd4, 3'd0, 8'h00);

    $display("[TB] random commands");
    for (int n = 0; n < 300; n++) begin
      s = 3'($urandom);
      d = 3'($urandom);
      applyStimulus(2'($urandom), s, d, 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
